// File: rtl/sbox_sched.sv
// sbox_sched: arbitrates state SubBytes/InvSubBytes jobs and key-schedule
// SubWord jobs onto one shared byte-wide s_box. Each granted job is streamed
// through the s_box at one byte per cycle, and the results are reassembled
// into the matching output register.
module sbox_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic         st_req,
  input  logic         st_encrypt,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         ks_req,
  input  logic [31:0]  ks_in,
  output logic [31:0]  ks_out,
  output logic         ks_done,
  output logic         busy,
  output logic [7:0]   sb_in,
  output logic         sb_ready,
  output logic         sb_encrypt,
  input  logic [7:0]   sb_out,
  input  logic         sb_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef enum logic {JOB_ST, JOB_KS} job_t;

  state_t       state, state_nxt;
  job_t         job, last_grant;
  logic         st_pend, ks_pend;
  logic         st_enc_lat;
  logic [127:0] st_lat;
  logic [31:0]  ks_lat;
  logic [3:0]   tx_cnt, rx_cnt, last_idx;
  logic [127:0] job_in, res_buf, res_nxt, grant_data;
  logic         grant_st, grant_ks, grant;
  logic         tx_last, rx_fire, rx_last;

  // Arbitration, byte-count compares, result merge and next-state selection.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    grant_st  = 1'b0;
    grant_ks  = 1'b0;
    last_idx  = (job == JOB_KS) ? 4'd3 : 4'd15;
    tx_last   = (tx_cnt == last_idx);
    // A done from the s_box only counts while a job is in flight; the s_box
    // does not clear it on reset, so in IDLE it may be stale.
    rx_fire   = (state != IDLE) && sb_done;
    rx_last   = rx_fire && (rx_cnt == last_idx);
    res_nxt   = res_buf;
    res_nxt[8*rx_cnt +: 8] = sb_out;
    case (state)
      IDLE: begin
        // Non-preemptive; on a tie the type not granted last wins.
        if (st_pend && (!ks_pend || last_grant == JOB_KS)) grant_st = 1'b1;
        else if (ks_pend)                                  grant_ks = 1'b1;
        if (grant_st || grant_ks) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (rx_last)      state_nxt = IDLE;
        else if (tx_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rx_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant      = grant_st | grant_ks;
  assign grant_data = grant_ks ? {96'd0, ks_lat} : st_lat;
  assign busy       = (state != IDLE);

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pends, counters, s_box drive and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_pend    <= 1'b0;
      ks_pend    <= 1'b0;
      last_grant <= JOB_KS;
      job        <= JOB_ST;
      tx_cnt     <= 4'd0;
      rx_cnt     <= 4'd0;
      st_out     <= 128'd0;
      ks_out     <= 32'd0;
      st_done    <= 1'b0;
      ks_done    <= 1'b0;
      sb_in      <= 8'd0;
      sb_ready   <= 1'b0;
      sb_encrypt <= 1'b0;
    end else begin
      st_done <= 1'b0;
      ks_done <= 1'b0;

      // A request while the same-type pend is still set is dropped; a grant
      // can only clear a pend that was already set, so the two never collide.
      if (st_req && !st_pend) st_pend <= 1'b1;
      else if (grant_st)      st_pend <= 1'b0;
      if (ks_req && !ks_pend) ks_pend <= 1'b1;
      else if (grant_ks)      ks_pend <= 1'b0;

      if (grant) begin
        job        <= grant_ks ? JOB_KS : JOB_ST;
        last_grant <= grant_ks ? JOB_KS : JOB_ST;
        tx_cnt     <= 4'd0;
        rx_cnt     <= 4'd0;
        sb_in      <= grant_data[7:0];
        sb_ready   <= 1'b1;
        sb_encrypt <= grant_ks ? 1'b1 : st_enc_lat;
      end else if (state == ISSUE) begin
        if (tx_last) begin
          sb_ready <= 1'b0;
        end else begin
          tx_cnt <= tx_cnt + 4'd1;
          sb_in  <= job_in[7:0];
        end
      end

      if (rx_fire) begin
        if (rx_last) begin
          rx_cnt <= 4'd0;
          if (job == JOB_KS) begin
            ks_out  <= res_nxt[31:0];
            ks_done <= 1'b1;
          end else begin
            st_out  <= res_nxt;
            st_done <= 1'b1;
          end
        end else begin
          rx_cnt <= rx_cnt + 4'd1;
        end
      end
    end
  end

  // Request data latches, outgoing byte shifter and result assembly buffer.
  // NOTE: these wide data registers are not reset: every byte that is consumed
  // was written earlier in the same job, so reset would carry no information.
  always_ff @(posedge clk) begin
    if (st_req && !st_pend) begin
      st_lat     <= st_in;
      st_enc_lat <= st_encrypt;
    end
    if (ks_req && !ks_pend) ks_lat <= ks_in;

    if (grant)                             job_in <= grant_data >> 8;
    else if ((state == ISSUE) && !tx_last) job_in <= job_in >> 8;

    if (rx_fire) res_buf <= res_nxt;
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Self-checking bench for sbox_sched: a behavioural s_box sits on the sb_*
// port, and a job-level reference model tracks pends, grants and the cycle
// each job must finish, checked against the DUT on every cycle.
module tb_sbox_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         st_req, st_encrypt;
  logic [127:0] st_in, st_out;
  logic         st_done;
  logic         ks_req;
  logic [31:0]  ks_in, ks_out;
  logic         ks_done, busy;
  logic [7:0]   sb_in, sb_out;
  logic         sb_ready, sb_encrypt;
  logic         sb_done = 1'b1;  // the s_box comes up with a stale done
  logic         inject;
  logic [7:0]   inj_byte;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    fwd_t [256];
  logic [7:0]    inv_t [256];
  logic [2047:0] tbl;

  always #5 clk = ~clk;

  sbox_sched dut (
    .clk        (clk),
    .reset      (reset),
    .st_req     (st_req),
    .st_encrypt (st_encrypt),
    .st_in      (st_in),
    .st_out     (st_out),
    .st_done    (st_done),
    .ks_req     (ks_req),
    .ks_in      (ks_in),
    .ks_out     (ks_out),
    .ks_done    (ks_done),
    .busy       (busy),
    .sb_in      (sb_in),
    .sb_ready   (sb_ready),
    .sb_encrypt (sb_encrypt),
    .sb_out     (sb_out),
    .sb_done    (sb_done)
  );

  // Behavioural s_box: ready sampled at edge k gives out/done after edge k.
  // inject forces a spurious done with a garbage byte while nothing is owed.
  always @(posedge clk) begin
    sb_done <= sb_ready | inject;
    sb_out  <= inject ? inj_byte : (sb_encrypt ? fwd_t[sb_in] : inv_t[sb_in]);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] x, input int n, input bit enc);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++)
      r[8*i +: 8] = enc ? fwd_t[x[8*i +: 8]] : inv_t[x[8*i +: 8]];
    return r;
  endfunction

  // ---------------- reference model (job level) ----------------
  bit           m_rst, m_st_pend, m_ks_pend, m_last_ks, m_act, m_job_ks;
  bit           m_st_enc, m_job_enc, m_st_done, m_ks_done;
  logic [127:0] m_st_lat, m_job_in, m_job_res, m_st_out;
  logic [31:0]  m_ks_lat, m_ks_out;
  int           m_edge, m_start, m_len;

  task automatic model_step();
    bit ost, oks, gst, gks;
    m_edge++;
    if (reset) begin
      m_rst = 1; m_st_pend = 0; m_ks_pend = 0; m_last_ks = 1; m_act = 0;
      m_st_out = '0; m_ks_out = '0; m_st_done = 0; m_ks_done = 0;
      return;
    end
    m_rst = 0; m_st_done = 0; m_ks_done = 0;
    ost = m_st_pend; oks = m_ks_pend; gst = 0; gks = 0;
    if (m_act) begin
      // grant at edge g, last result captured at g+N+1
      if (m_edge == m_start + m_len + 1) begin
        m_act = 0;
        if (m_job_ks) begin m_ks_out = m_job_res[31:0]; m_ks_done = 1; end
        else          begin m_st_out = m_job_res;       m_st_done = 1; end
      end
    end else if (ost && (!oks || m_last_ks)) gst = 1;
    else if (oks) gks = 1;
    if (gst || gks) begin
      m_act     = 1;
      m_start   = m_edge;
      m_job_ks  = gks;
      m_last_ks = gks;
      m_len     = gks ? 4 : 16;
      m_job_in  = gks ? {96'd0, m_ks_lat} : m_st_lat;
      m_job_enc = gks ? 1'b1 : m_st_enc;
      m_job_res = sub_bytes(m_job_in, m_len, m_job_enc);
    end
    m_st_pend = (ost && !gst) || (st_req && !ost);
    if (st_req && !ost) begin m_st_lat = st_in; m_st_enc = st_encrypt; end
    m_ks_pend = (oks && !gks) || (ks_req && !oks);
    if (ks_req && !oks) m_ks_lat = ks_in;
  endtask

  task automatic compare_all();
    int rel = m_edge - m_start;
    bit exp_rdy = m_act && (rel < m_len);
    check("st_done", st_done, m_st_done);
    check("ks_done", ks_done, m_ks_done);
    check("busy", busy, m_act);
    check("sb_ready", sb_ready, exp_rdy);
    check("st_out", st_out, m_st_out);
    check("ks_out", ks_out, m_ks_out);
    if (exp_rdy) check("sb_in", sb_in, m_job_in[8*rel +: 8]);
    if (m_act)   check("sb_encrypt", sb_encrypt, m_job_enc);
    if (m_rst) begin
      check("rst_sb_in", sb_in, 8'd0);
      check("rst_sb_enc", sb_encrypt, 1'b0);
    end
  endtask

  // One clock: model and DUT see the same edge, outputs compared at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    st_req = 1'b0;
    ks_req = 1'b0;
  endtask

  // Count cycles from the request edge until the chosen done pulse appears.
  task automatic wait_done(input bit is_st, input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if ((is_st ? st_done : ks_done) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, st_t, ks_t, st2_t, nst;
    logic [31:0]  ks_val;
    logic [127:0] st2_val;

    tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) begin
      fwd_t[i] = tbl[2047 - 8*i -: 8];
      inv_t[tbl[2047 - 8*i -: 8]] = i[7:0];
    end

    m_edge = 0; m_start = 0; m_len = 16; m_act = 0; m_rst = 1;
    m_st_pend = 0; m_ks_pend = 0; m_last_ks = 1;
    m_st_out = '0; m_ks_out = '0; m_st_done = 0; m_ks_done = 0;
    reset = 1'b1; st_req = 1'b0; ks_req = 1'b0; st_encrypt = 1'b0;
    st_in = '0; ks_in = '0; inject = 1'b0; inj_byte = 8'h00;

    // Reset state, with the s_box's stale done present throughout.
    repeat (3) tick();
    check("reset_st_out", st_out, 128'd0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // ST forward: 18 cycles, byte0 ff->16, byte15 00->63.
    st_in = 128'h00112233445566778899aabbccddeeff; st_encrypt = 1'b1; st_req = 1'b1;
    tick();
    wait_done(1'b1, 40, lat);
    check("st_fwd_lat", lat, 18);
    check("st_fwd_out", st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
    tick();

    // ST inverse restores the original state.
    st_in = 128'h638293c31bfc33f5c4eeacea4bc12816; st_encrypt = 1'b0; st_req = 1'b1;
    tick();
    wait_done(1'b1, 40, lat);
    check("st_inv_lat", lat, 18);
    check("st_inv_out", st_out, 128'h00112233445566778899aabbccddeeff);
    tick();

    // KS SubWord: 6 cycles, always forward.
    ks_in = 32'h09cf4f3c; ks_req = 1'b1;
    tick();
    wait_done(1'b0, 20, lat);
    check("ks_lat", lat, 6);
    check("ks_out", ks_out, 32'h018a84eb);

    // Tie right after reset: ST first. A second tie during the ST job finds
    // the KS pend still set (its data is dropped), a third st_req is a
    // duplicate; after ST completes KS wins the next tie.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    st_in = 128'd0; st_encrypt = 1'b1; st_req = 1'b1;
    ks_in = 32'h2b7e1516; ks_req = 1'b1;
    tick();
    st_t = -1; ks_t = -1; st2_t = -1; ks_val = '0; st2_val = '0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin
        st_req = 1'b1; st_in = 128'h00112233445566778899aabbccddeeff;
        ks_req = 1'b1; ks_in = 32'hdeadbeef;
      end
      if (n == 7) begin st_req = 1'b1; st_in = {128{1'b1}}; end
      tick();
      if (st_done === 1'b1) begin
        if (st_t < 0) begin
          st_t = n;
          check("tie_st_out", st_out, {16{8'h63}});
        end else if (st2_t < 0) begin
          st2_t = n; st2_val = st_out;
        end
      end
      if (ks_done === 1'b1 && ks_t < 0) begin ks_t = n; ks_val = ks_out; end
    end
    check("tie_st_done_at", st_t, 18);
    // KS granted at the edge after st_done, then N+1 more edges
    check("tie_ks_done_at", ks_t, 24);
    check("tie_ks_data", ks_val, 32'hf1f35947);
    check("st2_done_at", st2_t, 42);
    check("st2_dup_ignored", st2_val, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Reset at cycle 8 of an ST job, then a KS job with stale dones around.
    st_in = {$urandom, $urandom, $urandom, $urandom}; st_encrypt = 1'b1; st_req = 1'b1;
    tick();
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; inject = 1'b1; inj_byte = 8'h5a;
    check("abort_busy", busy, 1'b0);
    check("abort_ready", sb_ready, 1'b0);
    tick();
    ks_in = 32'h09cf4f3c; ks_req = 1'b1;
    tick();
    inject = 1'b0;
    nst = 0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (st_done === 1'b1) nst++;
      if (ks_done === 1'b1 && lat < 0) lat = n;
    end
    check("abort_no_st_done", nst, 0);
    check("abort_ks_lat", lat, 6);
    check("abort_ks_out", ks_out, 32'h018a84eb);

    // Randomized traffic, occasional resets and stale dones while quiet.
    for (int c = 0; c < 700; c++) begin
      st_req     = ($urandom_range(0, 11) == 0);
      st_in      = {$urandom, $urandom, $urandom, $urandom};
      st_encrypt = $urandom_range(0, 1);
      ks_req     = ($urandom_range(0, 7) == 0);
      ks_in      = $urandom;
      reset      = ($urandom_range(0, 249) == 0);
      inject     = !m_act && !m_st_pend && !m_ks_pend && ($urandom_range(0, 2) == 0);
      inj_byte   = $urandom_range(0, 255);
      tick();
    end
    reset = 1'b0; inject = 1'b0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
